// File: rtl/cic_decimator.sv
// N-stage CIC decimator: integrators at the input rate, combs at the decimated rate.
// Optional macro CIC_DEC_ROUND_EN selects round-half-up with positive saturation on the output.
module cic_decimator #(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 16,
   parameter int N_STAGES  = 3,
   parameter int R         = 8,
   parameter int M         = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic signed [IN_WIDTH-1:0]  in_data,
   output logic                        out_valid,
   output logic signed [OUT_WIDTH-1:0] out_data
);

   localparam int W    = IN_WIDTH + N_STAGES * $clog2(R * M);
   localparam int PH_W = $clog2(R);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(R - 1);

`ifdef CIC_DEC_ROUND_EN
   localparam int RND_SH = (W > OUT_WIDTH) ? (W - OUT_WIDTH - 1) : 0;
   localparam logic [W:0] RND_ADD = (W > OUT_WIDTH) ? ((W + 1)'(1) << RND_SH) : (W + 1)'(0);
`endif

   function automatic logic signed [W-1:0] sext(input logic signed [IN_WIDTH-1:0] d);
      return {{(W - IN_WIDTH){d[IN_WIDTH-1]}}, d};
   endfunction

   // Only a positive overflow is possible since the rounding constant is non-negative.
   function automatic logic signed [OUT_WIDTH-1:0] scale_out(input logic signed [W-1:0] y);
`ifdef CIC_DEC_ROUND_EN
      logic [W:0] s;
      s = {y[W-1], y} + RND_ADD;
      if (!s[W] && s[W-1])
         return {1'b0, {(OUT_WIDTH - 1){1'b1}}};
      return s[W-1 -: OUT_WIDTH];
`else
      return y[W-1 -: OUT_WIDTH];
`endif
   endfunction

   logic signed [W-1:0]  integ_p0 [N_STAGES];
   logic [PH_W-1:0]      phase;
   logic                 dec_stb;

   logic signed [W-1:0]  comb_in   [N_STAGES];
   logic [N_STAGES-1:0]  comb_vin;
   logic signed [W-1:0]  comb_y_p1 [N_STAGES];
   logic signed [W-1:0]  comb_d_p1 [N_STAGES][M];
   logic [N_STAGES-1:0]  vld_p1;

   assign dec_stb = in_valid && (phase == PH_LAST);

   // Stage p0: integrators and phase counter, input rate, modulo 2^W
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < N_STAGES; k++) integ_p0[k] <= '0;
         phase <= '0;
      end else if (in_valid) begin
         integ_p0[0] <= integ_p0[0] + sext(in_data);
         for (int k = 1; k < N_STAGES; k++) integ_p0[k] <= integ_p0[k] + integ_p0[k-1];
         phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
      end
   end

   always_comb begin
      comb_in[0]  = integ_p0[N_STAGES-1];
      comb_vin[0] = dec_stb;
      for (int k = 1; k < N_STAGES; k++) begin
         comb_in[k]  = comb_y_p1[k-1];
         comb_vin[k] = vld_p1[k-1];
      end
   end

   // Stage p1: comb chain, one stage per clock, state moves only with its valid bit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1 <= '0;
         for (int k = 0; k < N_STAGES; k++) begin
            comb_y_p1[k] <= '0;
            for (int j = 0; j < M; j++) comb_d_p1[k][j] <= '0;
         end
      end else begin
         vld_p1 <= comb_vin;
         for (int k = 0; k < N_STAGES; k++) begin
            if (comb_vin[k]) begin
               comb_y_p1[k]    <= comb_in[k] - comb_d_p1[k][M-1];
               comb_d_p1[k][0] <= comb_in[k];
               for (int j = 1; j < M; j++) comb_d_p1[k][j] <= comb_d_p1[k][j-1];
            end
         end
      end
   end

   // Stage p2: output scaling register; out_data holds between pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= vld_p1[N_STAGES-1];
         if (vld_p1[N_STAGES-1])
            out_data <= scale_out(comb_y_p1[N_STAGES-1]);
      end
   end

endmodule
